// File: rtl/ctrl_pkg.sv
// Shared types for the sample-rate-converter sequencer: FSM state encoding,
// the datapath strobe bundle and the state-to-strobe decode used by legacy blocks.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_AINIT, S_MAC, S_RESULT, S_WRITE, S_OUTPUT, S_DONE
  } state_t;

  typedef struct packed {
    logic pc_clr;
    logic pc_incr;
    logic fetch;
    logic h_init;
    logic a_init;
    logic cnt;
    logic res_err;
    logic rf_rw;
    logic get_logic;
    logic new_in;
    logic new_out;
  } ctrl_strobe_t;

  // Index width: at least one bit so single-entry counters still have a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // new_in depends on the accept handshake, not on state alone, so it is left 0 here.
  function automatic ctrl_strobe_t decode(input state_t s);
    ctrl_strobe_t d;
    d = '0;
    case (s)
      S_FETCH:  begin d.fetch = 1'b1;  d.h_init = 1'b1;    end
      S_AINIT:  begin d.a_init = 1'b1; d.get_logic = 1'b1; end
      S_MAC:    begin d.cnt = 1'b1;    d.pc_incr = 1'b1;   end
      S_RESULT: begin d.res_err = 1'b1; d.rf_rw = 1'b1;    end
      S_WRITE:  d.rf_rw = 1'b1;
      S_OUTPUT: d.new_out = 1'b1;
      S_DONE:   begin d.pc_clr = 1'b1; d.rf_rw = 1'b1; d.get_logic = 1'b1; end
      default:  ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ctrl_seq_cnt.sv
// Wrapping index counter (0..MAX-1) with synchronous clear; tied to 0 when MAX==1.
module ctrl_seq_cnt
  import ctrl_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  output logic [idx_w(MAX)-1:0]   val,
  output logic                    last
);

  localparam int W = idx_w(MAX);

  generate
    if (MAX > 1) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst || clr)
          val <= '0;
        else if (inc)
          val <= last ? '0 : val + 1'b1;
      end
      assign last = (val == W'(MAX - 1));
    end else begin : g_tie
      logic unused_in;
      assign unused_in = ^{clk, rst, clr, inc};
      assign val  = '0;
      assign last = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/ctrl_seq.sv
// Control FSM for the SRC datapath: N_CH x N_PHASE output samples per input frame,
// N_TAPS MAC cycles each; all strobes registered from the next-state decode.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int N_TAPS  = 16,
  parameter int N_CH    = 2,
  parameter int N_PHASE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic                       pc_clr,
  output logic                       pc_incr,
  output logic                       fetch,
  output logic                       h_init,
  output logic                       a_init,
  output logic                       cnt,
  output logic                       res_err,
  output logic                       rf_rw,
  output logic                       get_logic,
  output logic                       new_in,
  output logic                       new_out,
  output logic [idx_w(N_CH)-1:0]     ch_idx,
  output logic [idx_w(N_PHASE)-1:0]  ph_idx,
  output logic [idx_w(N_TAPS)-1:0]   tap_idx,
  output logic                       busy
);

  state_t       state, next_state;
  ctrl_strobe_t strb_q, strb_nxt;
  logic         in_ready_nxt, busy_nxt;
  logic         tap_last, ph_last, ch_last;
  logic         out_hs;

  assign out_hs = (state == S_OUTPUT) && out_ready;

  ctrl_seq_cnt #(.MAX(N_TAPS)) u_tap (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == S_AINIT) || (state == S_DONE)),
    .inc  (state == S_MAC),
    .val  (tap_idx),
    .last (tap_last)
  );

  ctrl_seq_cnt #(.MAX(N_PHASE)) u_ph (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_DONE),
    .inc  (out_hs),
    .val  (ph_idx),
    .last (ph_last)
  );

  ctrl_seq_cnt #(.MAX(N_CH)) u_ch (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_DONE),
    .inc  (out_hs && ph_last),
    .val  (ch_idx),
    .last (ch_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      strb_q   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= next_state;
      strb_q   <= strb_nxt;
      in_ready <= in_ready_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:   next_state = (in_valid && in_ready) ? S_FETCH : S_IDLE;
      S_FETCH:  next_state = S_AINIT;
      S_AINIT:  next_state = S_MAC;
      S_MAC:    next_state = tap_last ? S_RESULT : S_MAC;
      S_RESULT: next_state = S_WRITE;
      S_WRITE:  next_state = S_OUTPUT;
      S_OUTPUT: begin
        if (!out_ready)
          next_state = S_OUTPUT;
        else if (ph_last && ch_last)
          next_state = S_DONE;
        else
          next_state = S_FETCH;
      end
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    strb_nxt        = decode(next_state);
    strb_nxt.new_in = (state == S_IDLE) && in_valid && in_ready;
    in_ready_nxt    = (next_state == S_IDLE);
    busy_nxt        = (next_state != S_IDLE);
  end

  assign pc_clr    = strb_q.pc_clr;
  assign pc_incr   = strb_q.pc_incr;
  assign fetch     = strb_q.fetch;
  assign h_init    = strb_q.h_init;
  assign a_init    = strb_q.a_init;
  assign cnt       = strb_q.cnt;
  assign res_err   = strb_q.res_err;
  assign rf_rw     = strb_q.rf_rw;
  assign get_logic = strb_q.get_logic;
  assign new_in    = strb_q.new_in;
  assign new_out   = strb_q.new_out;
  assign out_valid = strb_q.new_out;

endmodule
